// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bundle between the two writeback sources and the regfile.
//   master : writeback side, drives a_*/b_* requests and observes ready and we3/wa3/wd3
//   slave  : arbiter side, accepts requests and drives ready and the regfile write port
interface regfile_wport_arbiter_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 5
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, we3, wa3, wd3
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, we3, wa3, wd3
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the single regfile write port between writeback source A (ALU) and
// source B (load data). After reset it sweeps X0..X(ZERO_REG-1) to INIT_VALUE,
// then grants A/B round-robin, one registered write per cycle.
// Optional feature macro: RF_WBYPASS_EN adds a combinational read bypass of the
// registered-but-uncommitted write.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   wp (slave)        A/B valid/ready/addr/data, regfile we3/wa3/wd3 (registered)
//   init_done         high once the init sweep has finished
//   ra1/ra2, rd1_i/rd2_i, rd1_o/rd2_o   bypass read path (RF_WBYPASS_EN only)
module regfile_wport_arbiter #(
    parameter int unsigned     DW         = 64,
    parameter int unsigned     AW         = 5,
    parameter int unsigned     ZERO_REG   = 31,
    parameter logic [DW-1:0]   INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    regfile_wport_arbiter_if.slave   wp,
    output logic                     init_done
`ifdef RF_WBYPASS_EN
    ,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    input  logic [DW-1:0]            rd1_i,
    input  logic [DW-1:0]            rd2_i,
    output logic [DW-1:0]            rd1_o,
    output logic [DW-1:0]            rd2_o
`endif
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST_IDX  = AW'(ZERO_REG - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          we3_q, we3_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic          init_done_q, init_done_d;
    logic          grant_a, grant_b;

    // State and write-port registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            rr_ptr_q    <= RR_A;
            we3_q       <= 1'b0;
            wa3_q       <= '0;
            wd3_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            we3_q       <= we3_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state, grant and write-port selection.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        we3_d       = 1'b0;
        wa3_d       = wa3_q;
        wd3_d       = wd3_q;
        init_done_d = init_done_q;
        grant_a     = 1'b0;
        grant_b     = 1'b0;

        case (state_q)
            ST_INIT: begin
                we3_d = 1'b1;
                wa3_d = idx_q;
                wd3_d = INIT_VALUE;
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A wins when alone or when it holds the round-robin pointer.
                grant_a = wp.a_valid && (!wp.b_valid || (rr_ptr_q == RR_A));
                grant_b = wp.b_valid && !grant_a;
                if (grant_a) begin
                    rr_ptr_d = RR_B;
                    if (wp.a_addr != ZERO_ADDR) begin
                        we3_d = 1'b1;
                        wa3_d = wp.a_addr;
                        wd3_d = wp.a_data;
                    end
                end else if (grant_b) begin
                    rr_ptr_d = RR_A;
                    if (wp.b_addr != ZERO_ADDR) begin
                        we3_d = 1'b1;
                        wa3_d = wp.b_addr;
                        wd3_d = wp.b_data;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign wp.a_ready = grant_a;
    assign wp.b_ready = grant_b;
    assign wp.we3     = we3_q;
    assign wp.wa3     = wa3_q;
    assign wp.wd3     = wd3_q;
    assign init_done  = init_done_q;

`ifdef RF_WBYPASS_EN
    // Forward the registered write until the regfile commits it on the next edge.
    assign rd1_o = (we3_q && (wa3_q == ra1) && (ra1 != ZERO_ADDR)) ? wd3_q : rd1_i;
    assign rd2_o = (we3_q && (wa3_q == ra2) && (ra2 != ZERO_ADDR)) ? wd3_q : rd2_i;
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: init sweep, directed arbitration
// cases, randomized traffic against a round-robin reference, mid-run reset.
module tb_regfile_wport_arbiter;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic reset_n;
    logic init_done;

    always #5 clk = ~clk;

    regfile_wport_arbiter_if #(.DW(DW), .AW(AW)) wp ();

`ifdef RF_WBYPASS_EN
    logic [AW-1:0] ra1, ra2;
    logic [DW-1:0] rd1_i, rd2_i, rd1_o, rd2_o;
`endif

    regfile_wport_arbiter #(
        .DW(DW), .AW(AW), .ZERO_REG(31), .INIT_VALUE(64'd0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wp        (wp.slave),
        .init_done (init_done)
`ifdef RF_WBYPASS_EN
        ,
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1_i     (rd1_i),
        .rd2_i     (rd2_i),
        .rd1_o     (rd1_o),
        .rd2_o     (rd2_o)
`endif
    );

    // Regfile fed by the DUT write port; X31 writes are counted separately.
    logic [63:0] rf [32];
    int          x31_writes = 0;

    always @(posedge clk) begin
        if (wp.we3 === 1'b1) rf[wp.wa3] <= wp.wd3;
    end

    always @(posedge clk) begin
        if (wp.we3 === 1'b1 && wp.wa3 == 5'd31) x31_writes <= x31_writes + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [63:0] exp_rf [32];
    logic        m_prio_b;
    logic        exp_a, exp_b, exp_we;
    logic [4:0]  exp_wa;
    logic [63:0] exp_wd;
    logic        a_taken, b_taken;

    initial begin
        reset_n    = 1'b0;
        wp.a_valid = 1'b1;
        wp.a_addr  = '0;
        wp.a_data  = '0;
        wp.b_valid = 1'b1;
        wp.b_addr  = '0;
        wp.b_data  = '0;
`ifdef RF_WBYPASS_EN
        ra1 = '0; ra2 = '0; rd1_i = '0; rd2_i = '0;
`endif
        for (int r = 0; r < 32; r++) exp_rf[r] = 64'd0;

        // Reset state
        #2;
        check_eq("rst_we3", 64'(wp.we3), 64'd0);
        check_eq("rst_wa3", 64'(wp.wa3), 64'd0);
        check_eq("rst_wd3", wp.wd3, 64'd0);
        check_eq("rst_init_done", 64'(init_done), 64'd0);
        check_eq("rst_a_ready", 64'(wp.a_ready), 64'd0);
        check_eq("rst_b_ready", 64'(wp.b_ready), 64'd0);

        // Init sweep: 31 writes of 0 to X0..X30, requests ignored throughout
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            check_eq("init_a_ready", 64'(wp.a_ready), 64'd0);
            check_eq("init_b_ready", 64'(wp.b_ready), 64'd0);
            @(posedge clk); #1;
            check_eq("init_we3", 64'(wp.we3), 64'd1);
            check_eq("init_wa3", 64'(wp.wa3), 64'(k - 1));
            check_eq("init_wd3", wp.wd3, 64'd0);
            check_eq("init_done", 64'(init_done), (k == 31) ? 64'd1 : 64'd0);
        end
        wp.a_valid = 1'b0;
        wp.b_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("post_init_we3", 64'(wp.we3), 64'd0);
        check_eq("post_init_done", 64'(init_done), 64'd1);

        // Single A write of all-ones to X10
        wp.a_valid = 1'b1; wp.a_addr = 5'd10; wp.a_data = '1;
        #1;
        check_eq("a_only_a_ready", 64'(wp.a_ready), 64'd1);
        check_eq("a_only_b_ready", 64'(wp.b_ready), 64'd0);
        @(posedge clk); #1;
        wp.a_valid = 1'b0;
        check_eq("a_only_we3", 64'(wp.we3), 64'd1);
        check_eq("a_only_wa3", 64'(wp.wa3), 64'd10);
        check_eq("a_only_wd3", wp.wd3, '1);
        exp_rf[10] = '1;
        @(posedge clk); #1;
        check_eq("rf_x10", rf[10], '1);
        check_eq("idle_we3", 64'(wp.we3), 64'd0);

        // Single B write hands the pointer back to A
        wp.b_valid = 1'b1; wp.b_addr = 5'd5; wp.b_data = 64'd7;
        #1;
        check_eq("b_only_b_ready", 64'(wp.b_ready), 64'd1);
        @(posedge clk); #1;
        wp.b_valid = 1'b0;
        check_eq("b_only_wa3", 64'(wp.wa3), 64'd5);
        exp_rf[5] = 64'd7;

        // Both valid for six cycles: ABABAB, a write every cycle
        wp.a_valid = 1'b1; wp.a_addr = 5'd1; wp.a_data = 64'h11;
        wp.b_valid = 1'b1; wp.b_addr = 5'd2; wp.b_data = 64'h22;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("rr_a_ready", 64'(wp.a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            check_eq("rr_b_ready", 64'(wp.b_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
            check_eq("rr_we3", 64'(wp.we3), 64'd1);
            check_eq("rr_wa3", 64'(wp.wa3), (i % 2 == 0) ? 64'd1 : 64'd2);
            check_eq("rr_wd3", wp.wd3, (i % 2 == 0) ? 64'h11 : 64'h22);
        end
        wp.a_valid = 1'b0;
        wp.b_valid = 1'b0;
        exp_rf[1] = 64'h11;
        exp_rf[2] = 64'h22;

        // Write to XZR is accepted but dropped
        wp.b_valid = 1'b1; wp.b_addr = 5'd31; wp.b_data = 64'd5;
        #1;
        check_eq("zr_b_ready", 64'(wp.b_ready), 64'd1);
        @(posedge clk); #1;
        wp.b_valid = 1'b0;
        check_eq("zr_we3", 64'(wp.we3), 64'd0);
        @(posedge clk); #1;
        check_eq("zr_x31_writes", 64'(x31_writes), 64'd0);

        // Randomized traffic; B was granted last so A holds priority
        m_prio_b = 1'b0;
        a_taken  = 1'b1;
        b_taken  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!wp.a_valid || a_taken) begin
                wp.a_valid = ($urandom_range(3) != 0);
                wp.a_addr  = ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(31));
                wp.a_data  = {$urandom, $urandom};
            end
            if (!wp.b_valid || b_taken) begin
                wp.b_valid = ($urandom_range(3) != 0);
                wp.b_addr  = ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(31));
                wp.b_data  = {$urandom, $urandom};
            end
            #1;
            exp_a = wp.a_valid && (!wp.b_valid || !m_prio_b);
            exp_b = wp.b_valid && !exp_a;
            check_eq("rnd_a_ready", 64'(wp.a_ready), 64'(exp_a));
            check_eq("rnd_b_ready", 64'(wp.b_ready), 64'(exp_b));
            exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
            if (exp_a && wp.a_addr != 5'd31) begin
                exp_we = 1'b1; exp_wa = wp.a_addr; exp_wd = wp.a_data;
            end else if (exp_b && wp.b_addr != 5'd31) begin
                exp_we = 1'b1; exp_wa = wp.b_addr; exp_wd = wp.b_data;
            end
            if (exp_we) exp_rf[exp_wa] = exp_wd;
            if (exp_a) m_prio_b = 1'b1;
            else if (exp_b) m_prio_b = 1'b0;
            a_taken = wp.a_valid && wp.a_ready;
            b_taken = wp.b_valid && wp.b_ready;
            @(posedge clk); #1;
            check_eq("rnd_we3", 64'(wp.we3), 64'(exp_we));
            if (exp_we) begin
                check_eq("rnd_wa3", 64'(wp.wa3), 64'(exp_wa));
                check_eq("rnd_wd3", wp.wd3, exp_wd);
            end
        end
        wp.a_valid = 1'b0;
        wp.b_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

`ifdef RF_WBYPASS_EN
        // Bypass of a registered write before the regfile commits it
        wp.a_valid = 1'b1; wp.a_addr = 5'd3; wp.a_data = 64'h1234;
        @(posedge clk); #1;
        wp.a_valid = 1'b0;
        exp_rf[3] = 64'h1234;
        ra1 = 5'd3; rd1_i = rf[3];
        ra2 = 5'd4; rd2_i = 64'hBEEF;
        #1;
        check_eq("byp_rd1_o", rd1_o, 64'h1234);
        check_eq("byp_rd2_o", rd2_o, 64'hBEEF);
        @(posedge clk); #1;
`endif

        for (int r = 0; r < 31; r++) check_eq("rf_final", rf[r], exp_rf[r]);
        check_eq("x31_writes_final", 64'(x31_writes), 64'd0);

        // Reset while a write is in flight
        wp.a_valid = 1'b1; wp.a_addr = 5'd4; wp.a_data = 64'd99;
        @(posedge clk); #1;
        check_eq("mid_we3_before", 64'(wp.we3), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_we3", 64'(wp.we3), 64'd0);
        check_eq("mid_rst_init_done", 64'(init_done), 64'd0);
        check_eq("mid_rst_a_ready", 64'(wp.a_ready), 64'd0);
        wp.a_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("restart_we3", 64'(wp.we3), 64'd1);
        check_eq("restart_wa3_0", 64'(wp.wa3), 64'd0);
        @(posedge clk); #1;
        check_eq("restart_wa3_1", 64'(wp.wa3), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
